// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: miss FSM states, AXI encodings and the
// address field split used by both the miss request unit and the fill unit.
package cc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } cc_state_e;

  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;

  localparam int unsigned CC_LINE_BEATS = 8;

  localparam int unsigned CC_TAG_W    = 17;
  localparam int unsigned CC_INDEX_W  = 9;
  localparam int unsigned CC_OFFSET_W = 6;

endpackage

// File: rtl/cc_miss_request_unit_if.sv
// AXI read-address and read-data observation signals between the miss
// request unit (master) and the memory side (slave).
interface cc_miss_request_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic              rvalid;
  logic              rlast;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rvalid, rlast
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rvalid, rlast
  );

endinterface

// File: rtl/cc_miss_request_unit.sv
// Blocking miss front end: pushes the miss address to the shared FIFO, issues
// one WRAP read burst per miss and stalls the lookup pipeline until the line lands.
module cc_miss_request_unit
  import cc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BEATS  = CC_LINE_BEATS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_i,
  input  logic [ADDR_W-1:0]     miss_addr_i,
  output logic                  stall_o,
  input  logic                  fifo_full_i,
  output logic                  fifo_wren_o,
  output logic [ADDR_W-1:0]     fifo_wdata_o,
  output logic                  burst_err_o,
  cc_miss_request_unit_if.master mem
);

  localparam logic [4:0] BeatsW = 5'(BEATS);

  cc_state_e         r_state;
  cc_state_e         w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_first;
  logic [3:0]        r_beat_cnt;
  logic              r_burst_err;

  logic              w_accept;
  logic              w_r_hs;
  logic [4:0]        w_beat_inc;
  logic              w_arvalid;
  logic              w_rready;
  logic              w_wren;

  assign w_accept   = (r_state == S_IDLE) & miss_i & ~fifo_full_i;
  assign w_r_hs     = mem.rvalid & w_rready;
  assign w_beat_inc = {1'b0, r_beat_cnt} + 5'd1;

  always_comb begin
    w_state_next = r_state;
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    w_wren       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_REQ;
      end
      S_REQ: begin
        w_arvalid = 1'b1;
        // Push only once, even if arready is held off for many cycles.
        w_wren    = r_first;
        if (mem.arready) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_rready = 1'b1;
        if (mem.rvalid && mem.rlast) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_first     <= 1'b0;
      r_beat_cnt  <= 4'd0;
      r_burst_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr  <= miss_addr_i;
        r_first <= 1'b1;
      end else if (r_state == S_REQ) begin
        r_first <= 1'b0;
      end
      if (w_r_hs) begin
        if (mem.rlast) begin
          r_beat_cnt <= 4'd0;
          if (w_beat_inc != BeatsW) r_burst_err <= 1'b1;
        end else begin
          r_beat_cnt <= w_beat_inc[3:0];
        end
      end
    end
  end

  assign stall_o      = miss_i | (r_state != S_IDLE);
  assign fifo_wren_o  = w_wren;
  assign fifo_wdata_o = r_addr;
  assign burst_err_o  = r_burst_err;

  assign mem.arid    = 4'd0;
  assign mem.araddr  = {r_addr[ADDR_W-1:3], 3'b000};
  assign mem.arlen   = 4'(BEATS - 1);
  assign mem.arsize  = AXI_SIZE_8B;
  assign mem.arburst = AXI_BURST_WRAP;
  assign mem.arvalid = w_arvalid;
  assign mem.rready  = w_rready;

endmodule
